if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline: PC register, next-PC/redirect mux, instruction-memory request handshake, and the IF/ID pipeline register.
- Sits directly upstream of the hazard detection unit.
  - Consumes PC_Write and IF_ID_Write from the hazard detection unit.
  - Consumes IF_Flush and PCSrc from the ID/EX branch/jump logic.
- Produces IF/ID contents for ID, including the Rs/Rt fields that feed hazard detection.

---
 rtl/if_fetch_stage.sv | 155 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect mux, imem request handshake
// and the IF/ID pipeline register.
// Optional performance counters are enabled with the macro IF_FETCH_PERF_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic        IF_Flush,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_ID_PC_plus4,
  output logic [31:0] IF_ID_Instruction,
  output logic        IF_ID_Valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buffer;
  logic        kill;
  logic [31:0] kill_addr;

  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        word_in;
  logic        load_mem;
  logic        load_buf;
  logic        advance;

  // Redirect target selection; unlisted PCSrc codes only squash
  always_comb begin
    redirect_valid  = 1'b1;
    redirect_target = pc;
    case (PCSrc)
      3'b001:  redirect_target = branch_target;
      3'b010:  redirect_target = jump_target;
      3'b011:  redirect_target = jr_target;
      3'b100:  redirect_target = EXC_VECTOR;
      default: redirect_valid  = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;

  // A usable word is one that returns for a live (non-killed) request
  // in a cycle that is not itself being flushed.
  assign word_in  = (state == S_WAIT) && imem_ready && !kill && !IF_Flush;
  assign load_mem = word_in && IF_ID_Write;
  assign load_buf = (state == S_HOLD) && IF_ID_Write && !IF_Flush;
  assign advance  = (load_mem || load_buf) && PC_Write;

  assign imem_req  = (state == S_WAIT);
  // While a killed response is still outstanding the bus keeps the old
  // address even though the PC has already been redirected.
  assign imem_addr = kill ? kill_addr : pc;
  assign IF_PC     = pc;

  // Fetch FSM, PC register and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      pc                <= {RESET_PC[31:2], 2'b00};
      buffer            <= '0;
      kill              <= 1'b0;
      kill_addr         <= '0;
      IF_ID_Instruction <= '0;
      IF_ID_PC_plus4    <= '0;
      IF_ID_Valid       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: begin
          if (imem_ready) begin
            kill <= 1'b0;
            if (!kill && !IF_Flush && !IF_ID_Write) begin
              buffer <= imem_rdata;
              state  <= S_HOLD;
            end
          end else if (IF_Flush && !kill) begin
            kill      <= 1'b1;
            kill_addr <= pc;
          end
        end
        S_HOLD: begin
          if (IF_Flush || IF_ID_Write) state <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase

      if (IF_Flush) begin
        IF_ID_Instruction <= '0;
        IF_ID_Valid       <= 1'b0;
      end else if (load_mem) begin
        IF_ID_Instruction <= imem_rdata;
        IF_ID_PC_plus4    <= pc_plus4;
        IF_ID_Valid       <= 1'b1;
      end else if (load_buf) begin
        IF_ID_Instruction <= buffer;
        IF_ID_PC_plus4    <= pc_plus4;
        IF_ID_Valid       <= 1'b1;
      end else if (IF_ID_Write) begin
        IF_ID_Instruction <= '0;
        IF_ID_Valid       <= 1'b0;
      end

      if (IF_Flush && redirect_valid) begin
        pc <= {redirect_target[31:2], 2'b00};
      end else if (advance) begin
        pc <= {pc_plus4[31:2], 2'b00};
      end
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if ((load_mem || load_buf) && !IF_Flush && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      if (!IF_ID_Write && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (IF_Flush && perf_flushes != '1)
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with a scoreboard of expected
// IF/ID loads and a simple address-derived instruction memory.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PC_Write = 1'b0;
  logic        IF_ID_Write = 1'b0;
  logic        IF_Flush = 1'b0;
  logic [2:0]  PCSrc = 3'b000;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] jr_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [31:0] IF_ID_PC_plus4;
  logic [31:0] IF_ID_Instruction;
  logic        IF_ID_Valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  if_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h8000_0008)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PC_Write         (PC_Write),
    .IF_ID_Write      (IF_ID_Write),
    .IF_Flush         (IF_Flush),
    .PCSrc            (PCSrc),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .jr_target        (jr_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .IF_PC            (IF_PC),
    .IF_ID_PC_plus4   (IF_ID_PC_plus4),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_Valid      (IF_ID_Valid)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_instr;
  logic [31:0] last_pc4;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_0001;
  endfunction

  assign imem_rdata = word_at(imem_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; PC_Write = 1'b1; IF_ID_Write = 1'b1; imem_ready = 1'b0;
    repeat (2) cyc();
    tests++;
    if ({imem_req, IF_PC, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: req=%0b pc=%h instr=%h pc4=%h valid=%0b, expected all zero", imem_req, IF_PC, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: req=%0b expected 0", imem_req);
    end
    cyc();
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL first_req: req=%0b addr=%h expected 1/00000000", imem_req, imem_addr);
    end
    exp_pc = 32'h0; last_instr = '0; last_pc4 = '0;
  endtask

  task automatic test_stream();
    imem_ready = 1'b1; IF_ID_Write = 1'b1; PC_Write = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (imem_addr !== exp_pc) begin
        fails++;
        $display("FAIL stream_addr[%0d]: addr=%h expected %h", i, imem_addr, exp_pc);
      end
      sb.push_back('{instr: word_at(exp_pc), pc4: exp_pc + 32'd4});
      cyc();
      exp_pc = exp_pc + 32'd4;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL stream_sb[%0d]: scoreboard empty", i);
      end else begin
        e = sb.pop_front();
        if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b1, e.instr, e.pc4, exp_pc}) begin
          fails++;
          $display("FAIL stream_load[%0d]: v=%0b instr=%h pc4=%h pc=%h expected 1 %h %h %h", i, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, e.instr, e.pc4, exp_pc);
        end
        last_instr = e.instr; last_pc4 = e.pc4;
      end
    end
  endtask

  task automatic test_hold();
    imem_ready = 1'b1; IF_ID_Write = 1'b0; PC_Write = 1'b0;
    sb.push_back('{instr: word_at(exp_pc), pc4: exp_pc + 32'd4});
    for (int i = 0; i < 3; i++) begin
      cyc();
      imem_ready = 1'b0;
      tests++;
      if ({imem_req, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b0, 1'b1, last_instr, last_pc4, exp_pc}) begin
        fails++;
        $display("FAIL hold_cycle[%0d]: req=%0b v=%0b instr=%h pc4=%h pc=%h expected 0 1 %h %h %h", i, imem_req, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, last_instr, last_pc4, exp_pc);
      end
    end
    IF_ID_Write = 1'b1; PC_Write = 1'b1;
    cyc();
    exp_pc = exp_pc + 32'd4;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL hold_sb: scoreboard empty");
    end else begin
      e = sb.pop_front();
      if ({imem_req, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b1, 1'b1, e.instr, e.pc4, exp_pc}) begin
        fails++;
        $display("FAIL hold_release: req=%0b v=%0b instr=%h pc4=%h pc=%h expected 1 1 %h %h %h", imem_req, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, e.instr, e.pc4, exp_pc);
      end
      last_pc4 = e.pc4;
    end
    cyc();
    tests++;
    if ({IF_PC, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4} !== {exp_pc, 1'b0, 32'h0, last_pc4}) begin
      fails++;
      $display("FAIL bubble_no_ready: pc=%h v=%0b instr=%h pc4=%h expected %h 0 00000000 %h", IF_PC, IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, exp_pc, last_pc4);
    end
  endtask

  task automatic test_flush_branch();
    imem_ready = 1'b1; IF_Flush = 1'b1; PCSrc = 3'b001; branch_target = 32'h0000_0102;
    PC_Write = 1'b0; IF_ID_Write = 1'b0;
    cyc();
    tests++;
    if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, imem_req, imem_addr} !== {1'b0, 32'h0, last_pc4, 32'h0000_0100, 1'b1, 32'h0000_0100}) begin
      fails++;
      $display("FAIL flush_branch: v=%0b instr=%h pc4=%h pc=%h req=%0b addr=%h expected 0 00000000 %h 00000100 1 00000100", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, imem_req, imem_addr, last_pc4);
    end
    IF_Flush = 1'b0; PCSrc = 3'b000; PC_Write = 1'b1; IF_ID_Write = 1'b1;
    exp_pc = 32'h0000_0100;
    sb.push_back('{instr: word_at(exp_pc), pc4: exp_pc + 32'd4});
    cyc();
    exp_pc = exp_pc + 32'd4;
    tests++;
    e = sb.pop_front();
    if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b1, e.instr, e.pc4, exp_pc}) begin
      fails++;
      $display("FAIL branch_target_fetch: v=%0b instr=%h pc4=%h pc=%h expected 1 %h %h %h", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, e.instr, e.pc4, exp_pc);
    end
  endtask

  task automatic test_flush_exc();
    logic [31:0] old_pc;
    old_pc = exp_pc;
    imem_ready = 1'b0; IF_Flush = 1'b1; PCSrc = 3'b100;
    cyc();
    tests++;
    if ({IF_PC, imem_addr, imem_req, IF_ID_Valid} !== {32'h8000_0008, old_pc, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL exc_kill: pc=%h addr=%h req=%0b v=%0b expected 80000008 %h 1 0", IF_PC, imem_addr, imem_req, IF_ID_Valid, old_pc);
    end
    IF_Flush = 1'b0; PCSrc = 3'b000;
    cyc();
    tests++;
    if (imem_addr !== old_pc) begin
      fails++;
      $display("FAIL exc_addr_held: addr=%h expected %h", imem_addr, old_pc);
    end
    imem_ready = 1'b1;
    cyc();
    tests++;
    if ({IF_ID_Valid, IF_ID_Instruction, imem_addr} !== {1'b0, 32'h0, 32'h8000_0008}) begin
      fails++;
      $display("FAIL exc_discard: v=%0b instr=%h addr=%h expected 0 00000000 80000008", IF_ID_Valid, IF_ID_Instruction, imem_addr);
    end
    exp_pc = 32'h8000_0008;
    sb.push_back('{instr: word_at(exp_pc), pc4: exp_pc + 32'd4});
    cyc();
    exp_pc = exp_pc + 32'd4;
    tests++;
    e = sb.pop_front();
    if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b1, e.instr, e.pc4, exp_pc}) begin
      fails++;
      $display("FAIL exc_vector_fetch: v=%0b instr=%h pc4=%h pc=%h expected 1 %h %h %h", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, e.instr, e.pc4, exp_pc);
    end
  endtask

  task automatic test_wrap_and_squash();
    imem_ready = 1'b1; IF_Flush = 1'b1; PCSrc = 3'b010; jump_target = 32'hFFFF_FFFF;
    cyc();
    tests++;
    if (IF_PC !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL jump_align: pc=%h expected fffffffc", IF_PC);
    end
    IF_Flush = 1'b0; PCSrc = 3'b000;
    sb.push_back('{instr: word_at(32'hFFFF_FFFC), pc4: 32'h0});
    cyc();
    tests++;
    e = sb.pop_front();
    if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b1, e.instr, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL pc_wrap: v=%0b instr=%h pc4=%h pc=%h expected 1 %h 00000000 00000000", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, e.instr);
    end
    IF_Flush = 1'b1; PCSrc = 3'b110;
    cyc();
    tests++;
    if ({IF_PC, IF_ID_Valid, IF_ID_Instruction} !== {32'h0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL squash_only: pc=%h v=%0b instr=%h expected 00000000 0 00000000", IF_PC, IF_ID_Valid, IF_ID_Instruction);
    end
    PCSrc = 3'b011; jr_target = 32'h0000_2006;
    cyc();
    tests++;
    if (IF_PC !== 32'h0000_2004) begin
      fails++;
      $display("FAIL jr_redirect: pc=%h expected 00002004", IF_PC);
    end
    IF_Flush = 1'b0; PCSrc = 3'b000;
    exp_pc = 32'h0000_2004;
  endtask

  task automatic test_reset_in_hold();
    imem_ready = 1'b1; IF_ID_Write = 1'b0; PC_Write = 1'b0;
    cyc();
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL hold_entry: req=%0b expected 0", imem_req);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if ({imem_req, IF_PC, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: req=%0b pc=%h instr=%h pc4=%h v=%0b expected all zero", imem_req, IF_PC, IF_ID_Instruction, IF_ID_PC_plus4, IF_ID_Valid);
    end
    sb.delete();
    IF_ID_Write = 1'b1; PC_Write = 1'b1;
    #1;
    reset = 1'b1;
    cyc();
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL refetch_reset_pc: req=%0b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
    sb.push_back('{instr: word_at(32'h0), pc4: 32'h4});
    cyc();
    tests++;
    e = sb.pop_front();
    if ({IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC} !== {1'b1, e.instr, e.pc4, 32'h4}) begin
      fails++;
      $display("FAIL post_reset_load: v=%0b instr=%h pc4=%h pc=%h expected 1 %h %h 00000004", IF_ID_Valid, IF_ID_Instruction, IF_ID_PC_plus4, IF_PC, e.instr, e.pc4);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_flush_branch();
    test_flush_exc();
    test_wrap_and_squash();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
